// File: rtl/st_align_unit.sv
// Store alignment unit: turns a MEM-stage store into one or two word-aligned
// write beats with byte strobes, pacing each beat on a valid/ack handshake.
module st_align_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [2:0]        req_f3,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    output logic              done,
    output logic              misaligned,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BEAT_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

    state_t            state_r;
    state_t            state_s;
    logic              ready_r;
    logic              legal_s;
    logic [7:0]        size_mask_s;
    logic [31:0]       data_n_s;
    logic [7:0]        mask8_s;
    logic [63:0]       data64_s;
    logic [ADDR_W-1:0] base_addr_s;

    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [3:0]        mem_wstrb_r;
    logic              done_r;
    logic              misaligned_r;
    logic              err_r;

    logic              mem_req_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [31:0]       mem_wdata_s;
    logic [3:0]        mem_wstrb_s;
    logic              done_s;
    logic              misaligned_s;
    logic              err_s;
    logic              load_s;

    // Second-beat contents captured at accept, replayed after beat 0 retires.
    logic              split_r;
    logic [ADDR_W-1:0] b1_addr_r;
    logic [31:0]       b1_wdata_r;
    logic [3:0]        b1_wstrb_r;

    // Decode funct3 into a byte mask and the significant data bits.
    always_comb begin
        legal_s     = 1'b0;
        size_mask_s = 8'h00;
        data_n_s    = 32'h0000_0000;
        case (req_f3)
            3'b000: begin
                legal_s     = 1'b1;
                size_mask_s = 8'h01;
                data_n_s    = {24'h00_0000, req_data[7:0]};
            end
            3'b001: begin
                legal_s     = 1'b1;
                size_mask_s = 8'h03;
                data_n_s    = {16'h0000, req_data[15:0]};
            end
            3'b010: begin
                legal_s     = 1'b1;
                size_mask_s = 8'h0F;
                data_n_s    = req_data;
            end
            default: begin
                legal_s     = 1'b0;
                size_mask_s = 8'h00;
                data_n_s    = 32'h0000_0000;
            end
        endcase
    end

    assign mask8_s     = size_mask_s << req_addr[1:0];
    assign data64_s    = {32'h0000_0000, data_n_s} << {req_addr[1:0], 3'b000};
    assign base_addr_s = {req_addr[ADDR_W-1:2], 2'b00};

    // Next-state and next-output logic; beat registers hold while ack is low.
    always_comb begin
        state_s      = state_r;
        mem_req_s    = 1'b0;
        mem_addr_s   = '0;
        mem_wdata_s  = 32'h0000_0000;
        mem_wstrb_s  = 4'b0000;
        done_s       = 1'b0;
        misaligned_s = 1'b0;
        err_s        = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && legal_s) begin
                    state_s     = BEAT0;
                    mem_req_s   = 1'b1;
                    mem_addr_s  = base_addr_s;
                    mem_wdata_s = data64_s[31:0];
                    mem_wstrb_s = mask8_s[3:0];
                    load_s      = 1'b1;
                end else if (req_valid) begin
                    done_s = 1'b1;
                    err_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BEAT0: begin
                if (mem_ack && split_r) begin
                    state_s     = BEAT1;
                    mem_req_s   = 1'b1;
                    mem_addr_s  = b1_addr_r;
                    mem_wdata_s = b1_wdata_r;
                    mem_wstrb_s = b1_wstrb_r;
                end else if (mem_ack) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    mem_req_s   = 1'b1;
                    mem_addr_s  = mem_addr_r;
                    mem_wdata_s = mem_wdata_r;
                    mem_wstrb_s = mem_wstrb_r;
                end
            end
            BEAT1: begin
                if (mem_ack) begin
                    state_s      = IDLE;
                    done_s       = 1'b1;
                    misaligned_s = 1'b1;
                end else begin
                    mem_req_s   = 1'b1;
                    mem_addr_s  = mem_addr_r;
                    mem_wdata_s = mem_wdata_r;
                    mem_wstrb_s = mem_wstrb_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            ready_r      <= 1'b1;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'h0000_0000;
            mem_wstrb_r  <= 4'b0000;
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            ready_r      <= (state_s == IDLE);
            mem_req_r    <= mem_req_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            mem_wstrb_r  <= mem_wstrb_s;
            done_r       <= done_s;
            misaligned_r <= misaligned_s;
            err_r        <= err_s;
        end
    end

    // Capture second-beat contents at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_r    <= 1'b0;
            b1_addr_r  <= '0;
            b1_wdata_r <= 32'h0000_0000;
            b1_wstrb_r <= 4'b0000;
        end else if (load_s) begin
            split_r    <= |mask8_s[7:4];
            b1_addr_r  <= base_addr_s + BEAT_STEP;
            b1_wdata_r <= data64_s[63:32];
            b1_wstrb_r <= mask8_s[7:4];
        end
    end

    assign req_ready  = ready_r;
    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wstrb  = mem_wstrb_r;
    assign done       = done_r;
    assign misaligned = misaligned_r;
    assign err        = err_r;

endmodule
